// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes and MDU start handshake.
// Optional saturating stall-cycle counter enabled by HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       exe_rd,
  input  logic             exe_reg_wen,
  input  logic             exe_is_load,
  input  logic             exe_mdu_op,
  input  logic             mdu_done,
  input  logic             mem_busy,
  input  logic             exe_redirect,
  output logic             mdu_req,
  output logic             if_stall,
  output logic             id_stall,
  output logic             exe_stall,
  output logic             mem_stall,
  output logic             id_flush,
  output logic             exe_flush,
  output logic             mem_bubble,
  output logic             wb_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    S_RUN,
    S_MDU
  } state_t;

  state_t state, state_nx;
  logic   mdu_fin, mdu_fin_nx;
  logic   mdu_pend;
  logic   rs1_hit, rs2_hit, load_use;

  assign mdu_pend = (state == S_MDU) || (exe_mdu_op && !mdu_fin);
  assign rs1_hit  = id_use_rs1 && (id_rs1 == exe_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == exe_rd);
  assign load_use = exe_is_load && exe_reg_wen &&
                    (exe_rd != 5'd0) && (rs1_hit || rs2_hit);

  // State and MDU-finished flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      mdu_fin <= 1'b0;
    end else begin
      state   <= state_nx;
      mdu_fin <= mdu_fin_nx;
    end
  end

  // Next state, MDU handshake and prioritised stall/flush controls
  always_comb begin
    state_nx   = state;
    mdu_fin_nx = mdu_fin;
    mdu_req    = 1'b0;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    exe_stall  = 1'b0;
    mem_stall  = 1'b0;
    id_flush   = 1'b0;
    exe_flush  = 1'b0;
    mem_bubble = 1'b0;
    wb_bubble  = 1'b0;

    unique case (state)
      S_RUN: begin
        if (exe_mdu_op && !mdu_fin && !mem_busy) begin
          mdu_req  = 1'b1;
          state_nx = S_MDU;
        end
      end
      S_MDU: begin
        if (mdu_done) begin
          mdu_fin_nx = 1'b1;
          state_nx   = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase

    if (mem_busy) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      exe_stall = 1'b1;
      mem_stall = 1'b1;
      wb_bubble = 1'b1;
    end else if (mdu_pend) begin
      if_stall   = 1'b1;
      id_stall   = 1'b1;
      exe_stall  = 1'b1;
      mem_bubble = 1'b1;
    end else if (exe_redirect) begin
      id_flush  = 1'b1;
      exe_flush = 1'b1;
    end else if (load_use) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      exe_flush = 1'b1;
    end

    // EXE instruction advancing ends its MDU ownership
    if (!exe_stall && state == S_RUN) begin
      mdu_fin_nx = 1'b0;
    end

    if (rst) begin
      mdu_req    = 1'b0;
      if_stall   = 1'b0;
      id_stall   = 1'b0;
      exe_stall  = 1'b0;
      mem_stall  = 1'b0;
      id_flush   = 1'b0;
      exe_flush  = 1'b0;
      mem_bubble = 1'b0;
      wb_bubble  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of cycles with the front end held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (if_stall && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic id_use_rs1, id_use_rs2;
  logic exe_reg_wen, exe_is_load, exe_mdu_op;
  logic mdu_done, mem_busy, exe_redirect;
  logic mdu_req, if_stall, id_stall, exe_stall, mem_stall;
  logic id_flush, exe_flush, mem_bubble, wb_bubble;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // req,if,id,exe,mem stall, id/exe flush, mem/wb bubble
  localparam logic [8:0] O_IDLE = 9'b000000000;
  localparam logic [8:0] O_LU   = 9'b011000100;
  localparam logic [8:0] O_MREQ = 9'b111100010;
  localparam logic [8:0] O_MDU  = 9'b011100010;
  localparam logic [8:0] O_BUSY = 9'b011110001;
  localparam logic [8:0] O_RDIR = 9'b000001100;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .exe_rd(exe_rd), .exe_reg_wen(exe_reg_wen),
    .exe_is_load(exe_is_load), .exe_mdu_op(exe_mdu_op),
    .mdu_done(mdu_done), .mem_busy(mem_busy),
    .exe_redirect(exe_redirect),
    .mdu_req(mdu_req), .if_stall(if_stall),
    .id_stall(id_stall), .exe_stall(exe_stall),
    .mem_stall(mem_stall), .id_flush(id_flush),
    .exe_flush(exe_flush), .mem_bubble(mem_bubble),
    .wb_bubble(wb_bubble), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {mdu_req, if_stall, id_stall, exe_stall, mem_stall,
            id_flush, exe_flush, mem_bubble, wb_bubble};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; exe_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    exe_reg_wen = 0; exe_is_load = 0; exe_mdu_op = 0;
    mdu_done = 0; mem_busy = 0; exe_redirect = 0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    exe_is_load = 1; exe_reg_wen = 1; exe_rd = rd;
    id_use_rs1 = 1; id_rs1 = 5'd5;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [CNT_W-1:0] cnt_sat;

  initial begin
    idle();
    rst = 1;
    #1;
    check("reset_outs", 32'(outs()), 32'(O_IDLE));
    check("reset_cnt", 32'(stall_cnt), 0);
    cyc(); rst = 0;
    #1 check("post_reset", 32'(outs()), 32'(O_IDLE));

    // load-use on rs1, then bubble in EXE clears it
    cyc(); load_use(5'd5);
    #1 check("lu_rs1", 32'(outs()), 32'(O_LU));
    cyc(); idle();
    #1 check("lu_one_cycle", 32'(outs()), 32'(O_IDLE));
    cyc(); load_use(5'd0); id_rs1 = 5'd0;
    #1 check("lu_x0", 32'(outs()), 32'(O_IDLE));
    cyc(); idle(); load_use(5'd7); id_use_rs1 = 0;
    id_use_rs2 = 1; id_rs2 = 5'd7;
    #1 check("lu_rs2", 32'(outs()), 32'(O_LU));
    id_use_rs2 = 0;
    #1 check("lu_unused", 32'(outs()), 32'(O_IDLE));
    exe_is_load = 0; id_use_rs2 = 1;
    #1 check("no_load", 32'(outs()), 32'(O_IDLE));

    // redirect overrides load-use
    cyc(); idle(); load_use(5'd5); exe_redirect = 1;
    #1 check("rdir_lu", 32'(outs()), 32'(O_RDIR));

    // MDU: req once, 9 stalled cycles, no re-issue
    cyc(); idle(); exe_mdu_op = 1;
    #1 check("mdu_req", 32'(outs()), 32'(O_MREQ));
    for (int i = 1; i <= 8; i++) begin
      cyc();
      mdu_done = (i == 8);
      #1 check($sformatf("mdu_wait%0d", i),
               32'(outs()), 32'(O_MDU));
    end
    cyc(); mdu_done = 0;
    #1 check("mdu_advance", 32'(outs()), 32'(O_IDLE));
    cyc(); exe_mdu_op = 0;
    #1 check("mdu_after", 32'(outs()), 32'(O_IDLE));

    // LSU wait defers redirect
    for (int i = 1; i <= 4; i++) begin
      cyc(); idle(); mem_busy = 1; exe_redirect = 1;
      #1 check($sformatf("busy%0d", i),
               32'(outs()), 32'(O_BUSY));
    end
    cyc(); mem_busy = 0;
    #1 check("rdir_deferred", 32'(outs()), 32'(O_RDIR));

    // reset mid-MDU, stray done ignored
    cyc(); idle(); exe_mdu_op = 1;
    #1 check("mdu_req2", 32'(outs()), 32'(O_MREQ));
    cyc(); cyc();
    #1 check("mdu_mid", 32'(outs()), 32'(O_MDU));
    rst = 1;
    #1 check("rst_mid", 32'(outs()), 32'(O_IDLE));
    cyc(); rst = 0; exe_mdu_op = 0;
    #1 check("rst_rel", 32'(outs()), 32'(O_IDLE));
    check("rst_cnt", 32'(stall_cnt), 0);
    cyc(); mdu_done = 1;
    #1 check("stray_done", 32'(outs()), 32'(O_IDLE));
    cyc(); mdu_done = 0;
    #1 check("stray_after", 32'(outs()), 32'(O_IDLE));
    cyc(); exe_mdu_op = 1;
    #1 check("run_state", 32'(outs()), 32'(O_MREQ));

    // saturating stall counter
    cyc(); rst = 1; idle();
    cyc(); rst = 0; load_use(5'd5);
    for (int i = 0; i < 20; i++) cyc();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    cnt_sat = 4'd15;
`else
    cnt_sat = 4'd0;
`endif
    check("cnt_sat", 32'(stall_cnt), 32'(cnt_sat));
    cyc();
    #1 check("cnt_hold", 32'(stall_cnt), 32'(cnt_sat));
    cyc(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
